// File: rtl/adder_tree_arbiter.sv
// Arbiter that shares one pipelined 25-input adder tree between N_REQ conv lanes and collects results in order.
// Optional round-robin arbitration via TREE_ARB_RR_EN; otherwise fixed priority (lowest lane wins).
module adder_tree_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int SUM_W     = 22,
  parameter int TREE_LAT  = 5,
  parameter int RES_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  output logic             tree_valid_in,
  output logic [ID_W-1:0]  tree_sel,
  input  logic             tree_valid_out,
  input  logic [SUM_W-1:0] tree_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ID_W-1:0]  res_id,
  output logic [SUM_W-1:0] res_sum,
  output logic             busy,
  output logic             err_orphan
);

  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int PTR_W = $clog2(RES_DEPTH);

  // A zero-latency tree would let a result return in its own issue cycle, which the tag FIFO cannot match.
  if (N_REQ < 2 || TREE_LAT < 1 || (32'd1 << PTR_W) != RES_DEPTH) begin : g_bad_params
    $error("adder_tree_arbiter: unsupported parameter set");
  end

  logic [ID_W-1:0]  tag_mem_r     [RES_DEPTH];
  logic [PTR_W-1:0] tag_wr_r;
  logic [PTR_W-1:0] tag_rd_r;
  logic [CNT_W-1:0] inflight_r;
  logic [ID_W-1:0]  res_id_mem_r  [RES_DEPTH];
  logic [SUM_W-1:0] res_sum_mem_r [RES_DEPTH];
  logic [PTR_W-1:0] res_wr_r;
  logic [PTR_W-1:0] res_rd_r;
  logic [CNT_W-1:0] occ_r;
  logic             err_orphan_r;

  logic [CNT_W:0]   credit_used_s;
  logic             issue_ok_s;
  logic             found_s;
  logic [ID_W-1:0]  pick_s;
  logic [ID_W-1:0]  cand_s;
  logic [N_REQ-1:0] grant_s;
  logic             issue_s;
  logic             ret_s;
  logic             orphan_s;
  logic             pop_res_s;
  logic             res_valid_s;

`ifdef TREE_ARB_RR_EN
  logic [ID_W-1:0]  rr_ptr_r;
`endif

  // Every issued window already owns a result slot, so the non-stallable tree can never overflow the FIFO.
  assign credit_used_s = {1'b0, inflight_r} + {1'b0, occ_r};
  assign issue_ok_s    = credit_used_s < (CNT_W + 1)'(RES_DEPTH);
  assign res_valid_s   = occ_r != {CNT_W{1'b0}};
  assign ret_s         = tree_valid_out & (inflight_r != {CNT_W{1'b0}});
  assign orphan_s      = tree_valid_out & (inflight_r == {CNT_W{1'b0}});
  assign pop_res_s     = res_valid_s & res_ready;

  // Search for the first requesting lane, starting at the round-robin pointer when enabled.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {ID_W{1'b0}};
    cand_s  = {ID_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
`ifdef TREE_ARB_RR_EN
      cand_s = ID_W'((32'(rr_ptr_r) + k) % N_REQ);
`else
      cand_s = ID_W'(k);
`endif
      if (!found_s && req_valid[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant; suppressed while reset is asserted so outputs drop immediately.
  always_comb begin
    grant_s = {N_REQ{1'b0}};
    if (issue_ok_s && found_s && !rst) begin
      grant_s[pick_s] = 1'b1;
    end else begin
      grant_s = {N_REQ{1'b0}};
    end
  end

  assign issue_s = |grant_s;

  // Tag FIFO: lane IDs of windows in flight, in issue order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RES_DEPTH; i++) tag_mem_r[i] <= {ID_W{1'b0}};
      tag_wr_r   <= {PTR_W{1'b0}};
      tag_rd_r   <= {PTR_W{1'b0}};
      inflight_r <= {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        tag_mem_r[tag_wr_r] <= pick_s;
        tag_wr_r            <= tag_wr_r + PTR_W'(1);
      end
      if (ret_s) tag_rd_r <= tag_rd_r + PTR_W'(1);
      inflight_r <= inflight_r + CNT_W'(issue_s) - CNT_W'(ret_s);
    end
  end

  // Result FIFO: {tag, sum} pairs with first-word fall-through head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        res_id_mem_r[i]  <= {ID_W{1'b0}};
        res_sum_mem_r[i] <= {SUM_W{1'b0}};
      end
      res_wr_r <= {PTR_W{1'b0}};
      res_rd_r <= {PTR_W{1'b0}};
      occ_r    <= {CNT_W{1'b0}};
    end else begin
      if (ret_s) begin
        res_id_mem_r[res_wr_r]  <= tag_mem_r[tag_rd_r];
        res_sum_mem_r[res_wr_r] <= tree_sum;
        res_wr_r                <= res_wr_r + PTR_W'(1);
      end
      if (pop_res_s) res_rd_r <= res_rd_r + PTR_W'(1);
      occ_r <= occ_r + CNT_W'(ret_s) - CNT_W'(pop_res_s);
    end
  end

  // Sticky flag for a tree result that has no matching tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_orphan_r <= 1'b0;
    end else if (orphan_s) begin
      err_orphan_r <= 1'b1;
    end else begin
      err_orphan_r <= err_orphan_r;
    end
  end

`ifdef TREE_ARB_RR_EN
  // Round-robin pointer moves just past the granted lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {ID_W{1'b0}};
    end else if (issue_s) begin
      rr_ptr_r <= (pick_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : pick_s + ID_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  assign req_ready     = grant_s;
  assign tree_valid_in = issue_s;
  assign tree_sel      = issue_s ? pick_s : {ID_W{1'b0}};
  assign res_valid     = res_valid_s;
  assign res_id        = res_id_mem_r[res_rd_r];
  assign res_sum       = res_sum_mem_r[res_rd_r];
  assign busy          = (inflight_r != {CNT_W{1'b0}}) | res_valid_s;
  assign err_orphan    = err_orphan_r;

endmodule
